svnseg_counter_mux: RTL

//  Multi-digit up/down counter with multiplexed seven-segment display. Two raw push keys are

---
 rtl/svnseg_pkg.sv | 62 ++++++
 rtl/svnseg_counter_mux_if.sv | 25 ++
 rtl/svnseg_key_filter.sv | 66 ++++++
 rtl/svnseg_counter_mux.sv | 137 +++++++++++++
 4 files changed

// File: rtl/svnseg_pkg.sv
// Shared glyph table, counter-op encoding and width helpers for the seven-segment counter.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package svnseg_pkg;

  typedef logic [6:0] seg_t;

  // What the counter does in a given cycle.
  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2
  } cnt_op_t;

  localparam int MAX_DIGITS = 8;

  // Active-low glyphs, segment a on bit 0 through g on bit 6.
  localparam seg_t SEG_0     = 7'b1000000;
  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_2     = 7'b0100100;
  localparam seg_t SEG_3     = 7'b0110000;
  localparam seg_t SEG_4     = 7'b0011001;
  localparam seg_t SEG_5     = 7'b0010010;
  localparam seg_t SEG_6     = 7'b0000010;
  localparam seg_t SEG_7     = 7'b1111000;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0010000;
  localparam seg_t SEG_A     = 7'b0001000;
  localparam seg_t SEG_B     = 7'b0000011;
  localparam seg_t SEG_C     = 7'b1000110;
  localparam seg_t SEG_D     = 7'b0100001;
  localparam seg_t SEG_E     = 7'b0000110;
  localparam seg_t SEG_F     = 7'b0001110;
  localparam seg_t SEG_BLANK = 7'b1111111;

  // Bits needed for a counter that runs 0..n-1; never less than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic seg_t hex_to_seg(input logic [3:0] nibble);
    case (nibble)
      4'h0:    return SEG_0;
      4'h1:    return SEG_1;
      4'h2:    return SEG_2;
      4'h3:    return SEG_3;
      4'h4:    return SEG_4;
      4'h5:    return SEG_5;
      4'h6:    return SEG_6;
      4'h7:    return SEG_7;
      4'h8:    return SEG_8;
      4'h9:    return SEG_9;
      4'hA:    return SEG_A;
      4'hB:    return SEG_B;
      4'hC:    return SEG_C;
      4'hD:    return SEG_D;
      4'hE:    return SEG_E;
      default: return SEG_F;
    endcase
  endfunction

endpackage

// File: rtl/svnseg_counter_mux_if.sv
// Key inputs and display/count outputs of the multiplexed seven-segment counter.
// Latency: n/a (wiring only).
// Backpressure: none; keys and display are free-running levels.
interface svnseg_counter_mux_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    KEY_INC;
  logic                    KEY_DEC;
  logic [4*NUM_DIGITS-1:0] COUNT;
  logic [NUM_DIGITS-1:0]   SVNSEG_DIG;
  logic [6:0]              SVNSEG_SEG;
  logic                    SVNSEG_DP;

  // Board / stimulus side: drives keys, observes the display.
  modport master (
    output KEY_INC, KEY_DEC,
    input  COUNT, SVNSEG_DIG, SVNSEG_SEG, SVNSEG_DP
  );

  // Counter side: consumes keys, drives the display.
  modport slave (
    input  KEY_INC, KEY_DEC,
    output COUNT, SVNSEG_DIG, SVNSEG_SEG, SVNSEG_DP
  );
endinterface

// File: rtl/svnseg_key_filter.sv
// Raw active-low key -> 2-flop sync -> debounced level -> one-cycle press pulse on 1->0.
// Latency: press fires DEBOUNCE_CYCLES+2 clocks after a clean key fall.
// Backpressure: none; the pulse is dropped if nobody samples it.
module svnseg_key_filter
  import svnseg_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic FPGA_CLK,
  input  logic FPGA_RST,
  input  logic key_in,
  output logic level,
  output logic press
);

  localparam int            CW   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_armed;
  logic          r_press;
  logic [CW-1:0] r_stab;
  logic          w_accept;

  assign w_accept = (r_sync2 != r_level) && (r_stab == LAST);

  // Synchroniser and stability counter; the level only moves after a full quiet window.
  always_ff @(posedge FPGA_CLK) begin
    if (FPGA_RST) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b1;
      r_stab  <= '0;
    end else begin
      r_sync1 <= key_in;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_level) begin
        r_stab <= '0;
      end else if (w_accept) begin
        r_stab  <= '0;
        r_level <= r_sync2;
      end else begin
        r_stab <= r_stab + 1'b1;
      end
    end
  end

  // Press pulse; a key held through reset must be seen released before it can count.
  always_ff @(posedge FPGA_CLK) begin
    if (FPGA_RST) begin
      r_armed <= 1'b0;
      r_press <= 1'b0;
    end else begin
      if (r_sync2) begin
        r_armed <= 1'b1;
      end
      r_press <= w_accept && r_level && r_armed;
    end
  end

  assign level = r_level;
  assign press = r_press;

endmodule

// File: rtl/svnseg_counter_mux.sv
// Multi-digit BCD/hex up/down key counter scanned onto a common-anode 7-seg display.
// Latency: COUNT moves 1 clock after a press pulse; display refreshes 1 clock after the count.
// Backpressure: none; simultaneous inc and dec cancel.
module svnseg_counter_mux
  import svnseg_pkg::*;
#(
  parameter int NUM_DIGITS      = 4,
  parameter int MODE_BCD        = 1,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int SCAN_DIV        = 25000,
  parameter int LZ_BLANK        = 1
) (
  input  logic                  FPGA_CLK,
  input  logic                  FPGA_RST,
  svnseg_counter_mux_if.slave   bus
);

  localparam int                 CW        = 4 * NUM_DIGITS;
  localparam int                 SCAN_W    = cnt_width(SCAN_DIV);
  localparam int                 IDX_W     = cnt_width(NUM_DIGITS);
  localparam logic [SCAN_W-1:0]  SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [3:0]         DIGIT_MAX = (MODE_BCD != 0) ? 4'd9 : 4'hF;

  logic                  w_inc_press;
  logic                  w_dec_press;
  logic                  w_inc_level_unused;
  logic                  w_dec_level_unused;
  cnt_op_t               w_op;
  logic [CW-1:0]         w_count_nxt;
  logic [NUM_DIGITS-1:0] w_blank;
  logic                  w_scan_tc;
  logic [IDX_W-1:0]      w_idx_nxt;

  logic [CW-1:0]         r_count;
  logic [SCAN_W-1:0]     r_scan;
  logic [IDX_W-1:0]      r_idx;
  logic [NUM_DIGITS-1:0] r_dig;
  seg_t                  r_seg;

  svnseg_key_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_inc (
    .FPGA_CLK (FPGA_CLK),
    .FPGA_RST (FPGA_RST),
    .key_in   (bus.KEY_INC),
    .level    (w_inc_level_unused),
    .press    (w_inc_press)
  );

  svnseg_key_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_dec (
    .FPGA_CLK (FPGA_CLK),
    .FPGA_RST (FPGA_RST),
    .key_in   (bus.KEY_DEC),
    .level    (w_dec_level_unused),
    .press    (w_dec_press)
  );

  // Pick the counter operation; both pulses together cancel out.
  always_comb begin
    w_op = CNT_HOLD;
    if (w_inc_press && !w_dec_press) begin
      w_op = CNT_INC;
    end else if (w_dec_press && !w_inc_press) begin
      w_op = CNT_DEC;
    end
  end

  // Next count: per-digit ripple carry/borrow, each digit wrapping at DIGIT_MAX.
  always_comb begin : p_count_nxt
    logic ripple;
    w_count_nxt = r_count;
    ripple      = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (ripple && (w_op == CNT_INC)) begin
        if (r_count[4*i +: 4] == DIGIT_MAX) begin
          w_count_nxt[4*i +: 4] = 4'd0;
        end else begin
          w_count_nxt[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
          ripple                = 1'b0;
        end
      end else if (ripple && (w_op == CNT_DEC)) begin
        if (r_count[4*i +: 4] == 4'd0) begin
          w_count_nxt[4*i +: 4] = DIGIT_MAX;
        end else begin
          w_count_nxt[4*i +: 4] = r_count[4*i +: 4] - 4'd1;
          ripple                = 1'b0;
        end
      end
    end
  end

  // Count register.
  always_ff @(posedge FPGA_CLK) begin
    if (FPGA_RST) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_nxt;
    end
  end

  // Leading-zero mask: digit i>0 blanks when it and every digit above it are zero.
  always_comb begin : p_blank
    logic upper_zero;
    w_blank    = '0;
    upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero && (r_count[4*i +: 4] == 4'd0);
      if ((LZ_BLANK != 0) && (i > 0)) begin
        w_blank[i] = upper_zero;
      end
    end
  end

  assign w_scan_tc = (r_scan == SCAN_LAST);
  assign w_idx_nxt = !w_scan_tc        ? r_idx :
                     (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;

  // Scan timer, digit index, and the digit/segment registers fed from the same next index.
  always_ff @(posedge FPGA_CLK) begin
    if (FPGA_RST) begin
      r_scan <= '0;
      r_idx  <= '0;
      r_dig  <= ~NUM_DIGITS'(1);
      r_seg  <= SEG_0;
    end else begin
      r_scan <= w_scan_tc ? '0 : r_scan + 1'b1;
      r_idx  <= w_idx_nxt;
      r_dig  <= ~(NUM_DIGITS'(1) << w_idx_nxt);
      r_seg  <= w_blank[w_idx_nxt] ? SEG_BLANK : hex_to_seg(r_count[4*w_idx_nxt +: 4]);
    end
  end

  assign bus.COUNT      = r_count;
  assign bus.SVNSEG_DIG = r_dig;
  assign bus.SVNSEG_SEG = r_seg;
  assign bus.SVNSEG_DP  = 1'b1;

endmodule
